// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared constants and width helper for the stream pipeline
package stream_pkg;

  localparam int MAX_STAGES = 8;

  // Occupancy counter width for a given depth; never narrower than one bit
  function automatic int cnt_w(input int stages);
    return (stages < 1) ? 1 : $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/stream_skid_stage.sv
// rtl/stream_skid_stage.sv - one two-entry registered valid/ready skid stage
module stream_skid_stage
  import stream_pkg::*;
#(
  parameter int DLEN = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DLEN-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DLEN-1:0] o_data
);

  logic            m_vld;
  logic            s_vld;
  logic [DLEN-1:0] m_dat;
  logic [DLEN-1:0] s_dat;
  logic            acc_in;
  logic            acc_out;

  // Ready comes straight from the skid flop, so it never depends on i_ready
  assign o_ready = ~s_vld;
  assign o_valid = m_vld;
  assign o_data  = m_dat;
  assign acc_in  = i_valid & ~s_vld;
  assign acc_out = m_vld & i_ready;

  // Valid flags: skid drains into main first, otherwise incoming beat fills main or skid
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (acc_out && s_vld) begin
      s_vld <= 1'b0;
    end else if (acc_in && m_vld && !acc_out) begin
      s_vld <= 1'b1;
    end else if (acc_in) begin
      m_vld <= 1'b1;
    end else if (acc_out) begin
      m_vld <= 1'b0;
    end
  end

  // Data registers are never reset; they are only meaningful under their valid flag
  always_ff @(posedge clk) begin
    if (acc_out && s_vld) begin
      m_dat <= s_dat;
    end else if (acc_in && (!m_vld || acc_out)) begin
      m_dat <= i_data;
    end
    if (acc_in && m_vld && !acc_out) begin
      s_dat <= i_data;
    end
  end

endmodule

// File: rtl/stream_pipe.sv
// rtl/stream_pipe.sv - cascade of skid stages with flush; STREAM_PIPE_COUNT_EN adds o_count
module stream_pipe
  import stream_pkg::*;
#(
  parameter int DLEN   = 8,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DLEN-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DLEN-1:0] o_data
`ifdef STREAM_PIPE_COUNT_EN
  ,
  output logic [cnt_w(STAGES)-1:0] o_count
`endif
);

  if (STAGES == 0) begin : g_pass
    // Zero depth is a plain wire-through with no state
    logic unused_ctl;
    assign unused_ctl = ^{clk, rstn, i_flush};
    assign o_valid    = i_valid;
    assign o_ready    = i_ready;
    assign o_data     = i_data;
  end else begin : g_pipe
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [DLEN-1:0] dat [0:STAGES];

    assign vld[0]      = i_valid;
    assign dat[0]      = i_data;
    assign rdy[STAGES] = i_ready;
    assign o_ready     = rdy[0];
    // Flush blocks any output transfer in the same cycle the pipe is being emptied
    assign o_valid     = vld[STAGES] & ~i_flush;
    assign o_data      = dat[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      stream_skid_stage #(
        .DLEN(DLEN)
      ) u_stage (
        .clk    (clk),
        .rstn   (rstn),
        .i_flush(i_flush),
        .i_valid(vld[g]),
        .o_ready(rdy[g]),
        .i_data (dat[g]),
        .o_valid(vld[g+1]),
        .i_ready(rdy[g+1]),
        .o_data (dat[g+1])
      );
    end
  end

`ifdef STREAM_PIPE_COUNT_EN
  localparam int CW = cnt_w(STAGES);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * STAGES);

  logic cnt_in;
  logic cnt_out;

  assign cnt_in  = i_valid & o_ready;
  assign cnt_out = o_valid & i_ready;

  // Occupancy tracks boundary transfers; simultaneous in and out leave it unchanged
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      o_count <= '0;
    end else if (cnt_in && !cnt_out) begin
      o_count <= o_count + 1'b1;
    end else if (cnt_out && !cnt_in) begin
      o_count <= o_count - 1'b1;
    end
  end

  // Occupancy can never exceed the two entries per stage
  always @(posedge clk) begin
    if (rstn) begin
      assert (o_count <= CNT_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_stream_pipe.sv
// tb/tb_stream_pipe.sv - scoreboard bench for stream_pipe at depths 2, 3 and 0
module tb_stream_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rstn, flush, vld, rdy, ordy, ovld;
  logic [7:0] din, dout;
  logic       flush3, v3, r3, or3, ov3;
  logic [7:0] d3, do3;
  logic       flush0, v0, r0, or0, ov0;
  logic [7:0] d0, do0;
`ifdef STREAM_PIPE_COUNT_EN
  logic [2:0] cnt, cnt3;
  logic [0:0] cnt0;
`endif

  stream_pipe #(.DLEN(8), .STAGES(2)) u_dut (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_valid(vld), .o_ready(ordy),
    .i_data(din), .o_valid(ovld), .i_ready(rdy), .o_data(dout)
`ifdef STREAM_PIPE_COUNT_EN
    , .o_count(cnt)
`endif
  );

  stream_pipe #(.DLEN(8), .STAGES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .i_flush(flush3), .i_valid(v3), .o_ready(or3),
    .i_data(d3), .o_valid(ov3), .i_ready(r3), .o_data(do3)
`ifdef STREAM_PIPE_COUNT_EN
    , .o_count(cnt3)
`endif
  );

  stream_pipe #(.DLEN(8), .STAGES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .i_flush(flush0), .i_valid(v0), .o_ready(or0),
    .i_data(d0), .o_valid(ov0), .i_ready(r0), .o_data(do0)
`ifdef STREAM_PIPE_COUNT_EN
    , .o_count(cnt0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor for the depth-2 pipe ----------------
  logic [7:0] q2[$];
  int cyc = 0, in_n = 0, out_n = 0, first_in = 0, first_out = 0, last_out = 0, mcnt2 = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      q2.delete();
      mcnt2 = 0;
    end else begin
`ifdef STREAM_PIPE_COUNT_EN
      chk("count2", 32'(cnt), 32'(mcnt2));
`endif
      if (ovld && rdy) begin
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out2_unexpected actual=%0h required=none", dout);
        end else begin
          chk("data2", 32'(dout), 32'(q2.pop_front()));
        end
        out_n++;
        if (out_n == 1) first_out = cyc;
        last_out = cyc;
        mcnt2--;
      end
      if (flush) begin
        q2.delete();
        mcnt2 = 0;
      end else if (vld && ordy) begin
        q2.push_back(din);
        in_n++;
        if (in_n == 1) first_in = cyc;
        mcnt2++;
      end
    end
  end

  // ---------------- scoreboard / monitor for the depth-3 pipe ----------------
  logic [7:0] q3[$];
  int out3_n = 0, mcnt3 = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      q3.delete();
      mcnt3 = 0;
    end else begin
`ifdef STREAM_PIPE_COUNT_EN
      chk("count3", 32'(cnt3), 32'(mcnt3));
`endif
      if (ov3 && r3) begin
        if (q3.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out3_unexpected actual=%0h required=none", do3);
        end else begin
          chk("data3", 32'(do3), 32'(q3.pop_front()));
        end
        out3_n++;
        mcnt3--;
      end
      if (v3 && or3) begin
        q3.push_back(d3);
        mcnt3++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int stalls = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [7:0] b);
    bit ok = 0;
    vld = 1'b1;
    din = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ordy) ok = 1;
      else stalls++;
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send2_timeout actual=blocked required=accept data=%0h", b);
    end
  endtask

  task automatic drain(input string name, input int which);
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (which == 2 && q2.size() == 0) done = 1;
      if (which == 3 && q3.size() == 0) done = 1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [9:0] vec0 [4] = '{10'b1_0_0000_0001, 10'b0_1_1010_0101, 10'b1_1_1111_1111, 10'b0_0_0011_1100};

  initial begin
    rstn = 0; flush = 0; vld = 0; rdy = 1; din = 8'h00;
    flush3 = 0; v3 = 0; r3 = 1; d3 = 8'h00;
    flush0 = 0; v0 = 0; r0 = 0; d0 = 8'h00;
    repeat (3) tick();
    rstn = 1;

    // reset state
    @(negedge clk);
    chk("reset_ovalid", 32'(ovld), 32'd0);
    chk("reset_oready", 32'(ordy), 32'd1);
`ifdef STREAM_PIPE_COUNT_EN
    chk("reset_count", 32'(cnt), 32'd0);
`endif
    tick();

    // back-to-back stream 0x00..0xFF with downstream always ready
    in_n = 0; out_n = 0; stalls = 0;
    for (int b = 0; b < 256; b++) send2(8'(b));
    vld = 0;
    drain("stream_drain", 2);
    repeat (4) tick();
    chk("stream_no_stall", 32'(stalls), 32'd0);
    chk("stream_out_n", 32'(out_n), 32'd256);
    chk("stream_latency", 32'(first_out - first_in), 32'd2);
    chk("stream_continuous", 32'(last_out - first_out), 32'd255);

    // backpressure: four beats fill a depth-2 pipe
    rdy = 0; in_n = 0; out_n = 0;
    for (int b = 0; b < 4; b++) send2(8'hA1 + 8'(b));
    vld = 0;
    @(negedge clk);
    chk("bp_oready", 32'(ordy), 32'd0);
    chk("bp_accepts", 32'(in_n), 32'd4);
    chk("bp_ovalid", 32'(ovld), 32'd1);
    chk("bp_head", 32'(dout), 32'hA1);
`ifdef STREAM_PIPE_COUNT_EN
    chk("bp_count", 32'(cnt), 32'd4);
`endif
    tick();
    rdy = 1;
    drain("bp_drain", 2);
    repeat (4) tick();
    chk("bp_out_n", 32'(out_n), 32'd4);

    // flush with three buffered beats and a beat offered in the flush cycle
    rdy = 0;
    send2(8'h10); send2(8'h11); send2(8'h12);
    vld = 1; din = 8'h55; flush = 1; rdy = 1;
    @(negedge clk);
    chk("flush_gate_ovalid", 32'(ovld), 32'd0);
    tick();
    flush = 0; vld = 0; out_n = 0;
    @(negedge clk);
    chk("flush_ovalid", 32'(ovld), 32'd0);
    chk("flush_oready", 32'(ordy), 32'd1);
`ifdef STREAM_PIPE_COUNT_EN
    chk("flush_count", 32'(cnt), 32'd0);
`endif
    repeat (8) tick();
    chk("flush_no_output", 32'(out_n), 32'd0);

    // reset while holding two beats, then a fresh beat passes through
    rdy = 0;
    send2(8'h21); send2(8'h22);
    vld = 0; rstn = 0;
    tick();
    rstn = 1;
    @(negedge clk);
    chk("mreset_ovalid", 32'(ovld), 32'd0);
    chk("mreset_oready", 32'(ordy), 32'd1);
`ifdef STREAM_PIPE_COUNT_EN
    chk("mreset_count", 32'(cnt), 32'd0);
`endif
    tick();
    rdy = 1; out_n = 0;
    send2(8'h3C);
    vld = 0;
    drain("mreset_drain", 2);
    repeat (4) tick();
    chk("mreset_out_n", 32'(out_n), 32'd1);

    // zero-depth pass-through: outputs follow inputs in the same cycle
    for (int i = 0; i < 4; i++) begin
      logic [9:0] v;
      v = vec0[i];
      v0 = v[9]; r0 = v[8]; d0 = v[7:0];
      #1;
      chk("pass_valid", 32'(ov0), 32'(v[9]));
      chk("pass_ready", 32'(or0), 32'(v[8]));
      chk("pass_data", 32'(do0), 32'(v[7:0]));
    end

    // random valid/ready traffic through a depth-3 pipe
    begin
      int sent = 0;
      bit acc = 0;
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
        if (!v3 || acc) begin
          v3 = 1'($urandom_range(0, 1));
          d3 = 8'($urandom);
        end
        r3 = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = v3 && or3;
        if (acc) sent++;
        tick();
      end
      v3 = 0; r3 = 1;
      chk("rand_sent", 32'(sent), 32'd10000);
      drain("rand_drain", 3);
      repeat (4) tick();
      chk("rand_out_n", 32'(out3_n), 32'(sent));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_pipe.md
Name: stream_pipe

Overview:
- Parametrised, fully registered valid/ready pipeline: a chain of STAGES two-entry skid stages.
- Generalises the single-entry skid buffer:
  - configurable data width and depth;
  - registered o_valid, o_data and o_ready at every stage boundary;
  - synchronous flush;
  - optional occupancy counter.
- Sits between the UART RX/TX datapaths and byte consumers, for timing closure and elastic buffering.

Parameters:
- DLEN, 8, data width in bits (>=1).
- STAGES, 2, number of cascaded skid stages (0..8). 0 = combinational pass-through.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- i_flush  in  1  synchronous flush; discards all buffered beats.
- i_valid  in  1  upstream valid.
- o_ready  out  1  upstream ready; registered when STAGES>0.
- i_data  in  DLEN  upstream data.
- o_valid  out  1  downstream valid.
- i_ready  in  1  downstream ready.
- o_data  out  DLEN  downstream data; registered when STAGES>0.
- o_count  out  $clog2(2*STAGES+1)  occupancy; present only with STREAM_PIPE_COUNT_EN.

Behaviour:
- Transfer rule: a beat moves on any edge where valid && ready at that interface.
- Valid rules:
  - Once asserted, valid holds and data stays stable until accepted. The block guarantees this on its output side and relies on it on its input side.
  - Valid never depends combinationally on ready.
- Per-stage state:
  - main register (m_vld, m_dat) drives the stage output;
  - skid register (s_vld, s_dat);
  - stage in_ready = ~s_vld, taken straight from a flop.
- Stage update each edge, with acc_in = in_valid & ~s_vld and acc_out = m_vld & out_ready:
  - acc_in & (~m_vld | acc_out): the beat loads main. If s_vld is set here, this case cannot arise.
  - acc_in & m_vld & ~acc_out: the beat loads skid, and s_vld is set.
  - acc_out & s_vld: skid moves into main, and s_vld is cleared.
  - acc_out & ~acc_in & ~s_vld: m_vld is cleared.
- Stages chain output-to-input. Stage 0 faces i_*; stage STAGES-1 drives o_*.
- Latency and throughput:
  - latency = STAGES cycles from input accept to o_valid when downstream is ready;
  - sustained throughput 1 beat/cycle;
  - capacity 2*STAGES beats.
- STAGES=0: o_valid=i_valid, o_ready=i_ready, o_data=i_data, no flops.
- Backpressure: with i_ready held low, o_ready deasserts after exactly 2*STAGES accepted beats. No beat is lost or duplicated.
- Simultaneous accept in and accept out at full occupancy cannot occur: o_ready=0 when stage 0 skid is full.
- Flush:
  - i_flush=1 clears every m_vld/s_vld at the next edge;
  - an input beat accepted in the flush cycle is discarded;
  - o_valid is gated to 0 combinationally while i_flush=1, so no output transfer occurs;
  - data registers are not cleared.
- Reset (rstn=0 at an edge), including mid-transfer:
  - all m_vld/s_vld = 0, so o_valid=0;
  - o_ready=1 from the first cycle after reset;
  - o_count=0;
  - data registers are not reset; o_data is don't-care while o_valid=0.

Optional Feature:
- Macro: STREAM_PIPE_COUNT_EN.
- Defined:
  - o_count port exists; registered occupancy, range 0..2*STAGES;
  - +1 on input accept, -1 on output accept, unchanged when both occur;
  - 0 on reset or flush;
  - an assertion checks that o_count never exceeds 2*STAGES.
- Undefined: no o_count port and no counter logic.

Decomposition:
- Package stream_pkg holds:
  - MAX_STAGES = 8;
  - function cnt_w(stages) returning $clog2(2*stages+1).
- Sub-module stream_skid_stage (DLEN): one two-entry stage. stream_pipe instantiates it STAGES times in a generate loop and adds flush gating and the counter.

Test Plan:
- DLEN=8, STAGES=2, i_ready=1, send 0x00..0xFF back-to-back -> each byte on o_data 2 cycles after accept, in order, o_valid continuous, o_ready never drops.
- STAGES=2, i_ready=0, push 0xA1,0xA2,... -> o_ready=0 after the 4th accept, o_count=4; release i_ready -> 0xA1..0xA4 emerge in order, no loss or duplicates.
- Random i_valid/i_ready (50%), STAGES=3, 10k beats -> scoreboard exact match, o_count matches the model every cycle.
- Fill STAGES=2 with 3 beats, pulse i_flush with i_valid=1 (0x55) -> o_valid=0 the next cycle, o_count=0, 0x55 never appears.
- Assert rstn=0 mid-stream with pipe holding 2 beats -> o_valid=0, o_ready=1, o_count=0 after reset; the next beat 0x3C exits normally.
- STAGES=0 -> o_valid/o_data/o_ready track i_valid/i_data/i_ready in the same cycle.
